// File: rtl/data_bus_arbiter.sv
// Two-master round-robin arbiter for the memory controller's data port.
// One transaction in flight: IDLE -> ISSUE -> WAIT -> RESP, with exception abort and timeout.
module data_bus_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_we,
  input  logic [1:0]  m0_wsize,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_done,
  output logic [31:0] m0_rdata,
  output logic [2:0]  m0_err,

  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic [1:0]  m1_wsize,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic [31:0] m1_rdata,
  output logic [2:0]  m1_err,

  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [1:0]  bus_wsize,
  output logic [31:0] bus_wdata,
  output logic        bus_valid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  input  logic [1:0]  bus_exc
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic          owner;      // master owning the in-flight transaction
  logic          last_srv;   // master granted most recently
  logic [31:0]   lat_addr, lat_wdata;
  logic          lat_we;
  logic [1:0]    lat_wsize;
  logic [CW-1:0] cnt;

  logic          any_req, pick;
  logic          res_load;
  logic [31:0]   res_rdata;
  logic [2:0]    res_err;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned
  // (which would infer a latch); blocking '=' is correct in combinational logic.
  always_comb begin
    state_nxt = state;
    any_req   = m0_req | m1_req;
    pick      = (m0_req && m1_req) ? ~last_srv : m1_req;
    res_load  = 1'b0;
    res_rdata = '0;
    res_err   = '0;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_done   = 1'b0;
    m1_done   = 1'b0;
    bus_valid = 1'b0;

    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = ISSUE;
          m0_gnt    = ~reset & ~pick;
          m1_gnt    = ~reset & pick;
        end
      end
      ISSUE: begin
        // Exceptions and the no-access window resolve here without touching a device.
        if (bus_exc != 2'b00) begin
          state_nxt = RESP;
          res_load  = 1'b1;
          res_err   = {1'b0, bus_exc};
        end else if (lat_wsize == 2'b11) begin
          state_nxt = RESP;
          res_load  = 1'b1;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        bus_valid = 1'b1;
        if (bus_ready) begin
          state_nxt = RESP;
          res_load  = 1'b1;
          res_rdata = lat_we ? 32'h0 : bus_rdata;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_nxt = RESP;
          res_load  = 1'b1;
          res_err   = 3'b100;
        end
      end
      RESP: begin
        state_nxt = IDLE;
        m0_done   = ~reset & ~owner;
        m1_done   = ~reset & owner;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= 1'b0;
      last_srv  <= 1'b1;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wsize <= 2'b11;
      lat_wdata <= '0;
      cnt       <= '0;
      m0_rdata  <= '0;
      m0_err    <= '0;
      m1_rdata  <= '0;
      m1_err    <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        owner     <= pick;
        last_srv  <= pick;
        lat_addr  <= pick ? m1_addr  : m0_addr;
        lat_we    <= pick ? m1_we    : m0_we;
        lat_wsize <= pick ? m1_wsize : m0_wsize;
        lat_wdata <= pick ? m1_wdata : m0_wdata;
      end

      if (state == ISSUE)
        cnt <= '0;
      else if (state == WAIT && state_nxt == WAIT)
        cnt <= cnt + CW'(1);

      // Result lands in the owner's registers on entry to RESP, so it is valid with done.
      if (res_load) begin
        if (owner) begin
          m1_rdata <= res_rdata;
          m1_err   <= res_err;
        end else begin
          m0_rdata <= res_rdata;
          m0_err   <= res_err;
        end
      end
    end
  end

  assign bus_addr  = lat_addr;
  assign bus_we    = lat_we;
  assign bus_wsize = lat_wsize;
  assign bus_wdata = lat_wdata;

endmodule
